// File: rtl/axi_line_bridge.sv
// AXI3 master shared by the I-cache and D-cache miss engines: line refills,
// line writebacks and single-beat uncached accesses, one transaction at a time.
module axi_line_bridge #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  I_ID       = 4'd0,
  parameter logic [3:0]  D_ID       = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // I-cache side
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_rvalid,
  output logic [31:0] ic_rdata,
  output logic        ic_done,
  // D-cache side
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic        dc_uncached,
  input  logic [31:0] dc_addr,
  input  logic [3:0]  dc_wstrb,
  input  logic [31:0] dc_wdata,
  output logic        dc_wnext,
  output logic        dc_rvalid,
  output logic [31:0] dc_rdata,
  output logic        dc_done,
  output logic        bus_err,
  output logic        stall,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [3:0]  LINE_LEN  = 4'(LINE_WORDS - 1);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        owner_dc_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  strb_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic        ic_rvalid_q, dc_rvalid_q;
  logic [31:0] rdata_q;

  // IDs are never checked with only one transaction in flight.
  logic unused_ids;
  always_comb unused_ids = ^{rid, bid};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_dc_q  <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      strb_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dc_req) begin
            owner_dc_q <= 1'b1;
            addr_q     <= dc_uncached ? dc_addr : (dc_addr & LINE_MASK);
            len_q      <= dc_uncached ? 4'd0 : LINE_LEN;
            strb_q     <= (dc_we && dc_uncached) ? dc_wstrb : 4'hF;
          end else if (ic_req) begin
            owner_dc_q <= 1'b0;
            addr_q     <= ic_addr & LINE_MASK;
            len_q      <= LINE_LEN;
            strb_q     <= 4'hF;
          end
        end
        S_R: begin
          if (rvalid) begin
            ic_rvalid_q <= ~owner_dc_q;
            dc_rvalid_q <= owner_dc_q;
            rdata_q     <= rdata;
            cnt_q       <= cnt_q + 4'd1;
            // A short or long burst is flagged alongside slave error responses.
            if ((rresp != 2'b00) || (rlast && (cnt_q != len_q))) err_q <= 1'b1;
          end
        end
        S_W: begin
          if (wready) cnt_q <= cnt_q + 4'd1;
        end
        S_B: begin
          if (bvalid && (bresp != 2'b00)) err_q <= 1'b1;
        end
        S_DONE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (dc_req)      state_d = dc_we ? S_AW : S_AR;
        else if (ic_req) state_d = S_AR;
      end
      S_AR:    if (arready) state_d = S_R;
      S_R:     if (rvalid && rlast) state_d = S_DONE;
      S_AW:    if (awready) state_d = S_W;
      S_W:     if (wready && (cnt_q == len_q)) state_d = S_B;
      S_B:     if (bvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = (state_q == S_AR);
    rready    = (state_q == S_R);
    awvalid   = (state_q == S_AW);
    wvalid    = (state_q == S_W);
    bready    = (state_q == S_B);
    araddr    = addr_q;
    awaddr    = addr_q;
    arlen     = len_q;
    awlen     = len_q;
    arsize    = 3'b010;
    awsize    = 3'b010;
    arburst   = 2'b01;
    awburst   = 2'b01;
    arlock    = '0;
    awlock    = '0;
    arcache   = '0;
    awcache   = '0;
    arprot    = '0;
    awprot    = '0;
    arid      = owner_dc_q ? D_ID : I_ID;
    awid      = D_ID;
    wid       = D_ID;
    wdata     = wvalid ? dc_wdata : '0;
    wstrb     = strb_q;
    wlast     = wvalid && (cnt_q == len_q);
    dc_wnext  = wvalid && wready;
    ic_rvalid = ic_rvalid_q;
    dc_rvalid = dc_rvalid_q;
    ic_rdata  = rdata_q;
    dc_rdata  = rdata_q;
    ic_done   = (state_q == S_DONE) && !owner_dc_q;
    dc_done   = (state_q == S_DONE) && owner_dc_q;
    bus_err   = (state_q == S_DONE) && err_q;
    stall     = (ic_req | dc_req) & ~(ic_done | dc_done);
  end

endmodule

// File: tb/tb_axi_line_bridge.sv
// Scoreboard bench for axi_line_bridge: a random AXI slave, a cache-side driver
// and an independent monitor checking against a transaction-level model.
module tb_axi_line_bridge;

  localparam int unsigned LW   = 8;
  localparam logic [3:0]  IID  = 4'd0;
  localparam logic [3:0]  DID  = 4'd1;
  localparam logic [3:0]  LLEN = 4'(LW - 1);

  logic clk = 1'b0;
  logic rst;
  logic ic_req, ic_rvalid, ic_done;
  logic [31:0] ic_addr, ic_rdata;
  logic dc_req, dc_we, dc_uncached, dc_wnext, dc_rvalid, dc_done, bus_err, stall;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0] dc_wstrb;
  logic [3:0] awid, awlen, awcache, wid, wstrb, bid, arid, arlen, arcache, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic [1:0] awburst, awlock, bresp, arburst, arlock, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_line_bridge #(.LINE_WORDS(LW), .I_ID(IID), .D_ID(DID)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_uncached(dc_uncached), .dc_addr(dc_addr),
    .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata), .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_done(dc_done), .bus_err(bus_err), .stall(stall),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed { logic wr; logic [31:0] addr; logic [3:0] len; logic [3:0] id; } addr_t;
  typedef struct packed { logic dc; logic err; } done_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct packed { logic signed [7:0] err_beat; logic [1:0] rerr; logic berr; logic [3:0] wstall; } plan_t;

  localparam plan_t NO_PLAN = '{err_beat: -8'sd1, rerr: 2'b00, berr: 1'b0, wstall: 4'd0};

  addr_t       exp_addr_q[$];
  logic [31:0] exp_ic_q[$];
  logic [31:0] exp_dc_q[$];
  done_t       exp_done_q[$];
  wbeat_t      exp_w_q[$];
  plan_t       plan_q[$];
  logic [31:0] wr_src_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          slv_beat = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h expected nothing", nm, act);
  endtask

  // Backing memory seen by the slave: any fixed address-to-word scramble.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a * 32'd2654435761);
  endfunction

  function automatic plan_t pop_plan();
    if (plan_q.size() == 0) return NO_PLAN;
    return plan_q.pop_front();
  endfunction

  // Transaction-level model: what the bus and the cache should see.
  task automatic expect_txn(input logic dc, input logic we, input logic unc,
                            input logic [31:0] addr, input logic [3:0] strb, input plan_t p);
    logic [31:0] base;
    logic [31:0] w;
    logic [3:0]  len;
    int          n;
    logic        err;
    if (dc && unc) begin
      base = addr;
      len  = 4'd0;
    end else begin
      base = (addr / (LW * 4)) * (LW * 4);
      len  = LLEN;
    end
    n = int'(len) + 1;
    exp_addr_q.push_back('{wr: we, addr: base, len: len, id: (dc ? DID : IID)});
    if (we) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        wr_src_q.push_back(w);
        exp_w_q.push_back('{data: w, strb: (unc ? strb : 4'hF), last: (i == n - 1)});
      end
      err = p.berr;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (dc) exp_dc_q.push_back(mem_word(base + 32'(4 * i)));
        else    exp_ic_q.push_back(mem_word(base + 32'(4 * i)));
      end
      err = (int'(p.err_beat) >= 0) && (int'(p.err_beat) < n);
    end
    exp_done_q.push_back('{dc: dc, err: err});
    plan_q.push_back(p);
  endtask

  task automatic issue(input logic dc, input logic we, input logic unc,
                       input logic [31:0] addr, input logic [3:0] strb, input plan_t p);
    expect_txn(dc, we, unc, addr, strb, p);
    if (dc) begin
      dc_req = 1'b1; dc_we = we; dc_uncached = unc; dc_addr = addr; dc_wstrb = strb;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete(); exp_ic_q.delete(); exp_dc_q.delete();
    exp_done_q.delete(); exp_w_q.delete(); plan_q.delete(); wr_src_q.delete();
  endtask

  task automatic wait_done(input logic want_ic, input logic want_dc);
    logic got_ic, got_dc;
    int   cyc;
    got_ic = !want_ic; got_dc = !want_dc; cyc = 0;
    while (!(got_ic && got_dc)) begin
      @(negedge clk);
      if (ic_done) begin got_ic = 1'b1; ic_req = 1'b0; end
      if (dc_done) begin got_dc = 1'b1; dc_req = 1'b0; end
      cyc++;
      if (cyc > 3000) begin
        unexpected("done_timeout", {got_ic, got_dc});
        apply_reset();
        return;
      end
    end
  endtask

  function automatic plan_t rand_plan(input logic we);
    plan_t p;
    p = NO_PLAN;
    if (!we && $urandom_range(0, 4) == 0) begin
      p.err_beat = 8'($urandom_range(0, LW - 1));
      p.rerr     = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
    end
    if (we && $urandom_range(0, 4) == 0) p.berr = 1'b1;
    if (we && $urandom_range(0, 3) == 0) p.wstall = 4'($urandom_range(1, 2));
    return p;
  endfunction

  // AXI slave and D-cache write-word source; DUT-facing changes only at negedge.
  initial begin : slave
    plan_t       cur;
    logic        r_act, b_pend, r_hs, b_hs, adv;
    int          beat, wst;
    logic [31:0] r_base;
    logic [3:0]  r_len;
    cur = NO_PLAN; r_act = 0; b_pend = 0; r_hs = 0; b_hs = 0; adv = 0;
    beat = 0; wst = 0; r_base = '0; r_len = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
    rid = '0; bvalid = 0; bresp = '0; bid = DID; dc_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = NO_PLAN; r_act = 0; b_pend = 0; r_hs = 0; b_hs = 0; adv = 0; wst = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0;
        continue;
      end
      if (adv && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
      adv = 0;
      dc_wdata = (wr_src_q.size() > 0) ? wr_src_q[0] : 32'h0;
      if (r_hs) begin rvalid = 0; rlast = 0; rresp = '0; r_hs = 0; end
      if (b_hs) begin bvalid = 0; bresp = '0; b_hs = 0; end
      arready = ($urandom_range(0, 1) != 0);
      awready = ($urandom_range(0, 1) != 0);
      wready  = (cur.wstall != 0) ? (wst >= int'(cur.wstall)) : ($urandom_range(0, 2) != 0);
      if (r_act && !rvalid && $urandom_range(0, 3) != 0) begin
        rvalid = 1;
        rdata  = mem_word(r_base + 32'(4 * beat));
        rresp  = (beat == int'(cur.err_beat)) ? cur.rerr : 2'b00;
        rlast  = (beat == int'(r_len));
      end
      if (b_pend && !bvalid && $urandom_range(0, 1) != 0) begin
        bvalid = 1;
        bresp  = cur.berr ? 2'b10 : 2'b00;
      end
      #1;
      if (rst) continue;
      if (arvalid && arready) begin
        cur = pop_plan(); r_act = 1; beat = 0; slv_beat = 0; r_base = araddr; r_len = arlen;
      end
      if (rvalid && rready) begin
        r_hs = 1; beat++; slv_beat = beat;
        if (rlast) r_act = 0;
      end
      if (awvalid && awready) begin cur = pop_plan(); wst = 0; end
      if (wvalid) begin
        if (wready) begin adv = 1; wst = 0; if (wlast) b_pend = 1; end
        else wst++;
      end
      if (bvalid && bready) begin b_hs = 1; b_pend = 0; end
    end
  end

  // Monitor: everything sampled 2 time units after the negedge, when all is settled.
  initial begin : monitor
    logic        rst_prev, w_hold, ar_hold;
    logic [31:0] w_prev;
    addr_t       a;
    wbeat_t      wb;
    done_t       d;
    rst_prev = 1; w_hold = 0; ar_hold = 0; w_prev = '0;
    forever begin
      @(negedge clk);
      #2;
      chk("stall", stall, (ic_req | dc_req) & ~(ic_done | dc_done));
      if (rst_prev) begin
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, dc_wnext}, '0);
        chk("rst_outs", {ic_rvalid, dc_rvalid, ic_done, dc_done, bus_err}, '0);
        chk("rst_addr", {araddr, awaddr, arlen, awlen}, '0);
        chk("rst_ids", {arid, awid, wid}, {IID, DID, DID});
        chk("rst_attr", {arsize, awsize, arburst, awburst}, {3'b010, 3'b010, 2'b01, 2'b01});
        chk("rst_lcp", {arlock, awlock, arcache, awcache, arprot, awprot}, '0);
      end else begin
        if (ic_rvalid) begin
          if (exp_ic_q.size() == 0) unexpected("ic_rdata_extra", ic_rdata);
          else chk("ic_rdata", ic_rdata, exp_ic_q.pop_front());
        end
        if (dc_rvalid) begin
          if (exp_dc_q.size() == 0) unexpected("dc_rdata_extra", dc_rdata);
          else chk("dc_rdata", dc_rdata, exp_dc_q.pop_front());
        end
        if (ic_done || dc_done) begin
          chk("done_exclusive", ic_done & dc_done, 1'b0);
          if (exp_done_q.size() == 0) unexpected("done_extra", {ic_done, dc_done});
          else begin
            d = exp_done_q.pop_front();
            chk("done_owner", {ic_done, dc_done}, {~d.dc, d.dc});
            chk("bus_err", bus_err, d.err);
          end
        end else if (bus_err) unexpected("bus_err_without_done", bus_err);
        if (ar_hold) chk("arvalid_hold", arvalid, 1'b1);
        if (w_hold) begin
          chk("wvalid_hold", wvalid, 1'b1);
          chk("wdata_hold", wdata, w_prev);
        end
        if (!rst) begin
          if (arvalid && awvalid) unexpected("ar_aw_overlap", {arvalid, awvalid});
          if (arvalid && arready) begin
            if (exp_addr_q.size() == 0) unexpected("ar_extra", araddr);
            else begin
              a = exp_addr_q.pop_front();
              chk("ar_is_read", a.wr, 1'b0);
              chk("araddr", araddr, a.addr);
              chk("arlen", arlen, a.len);
              chk("arid", arid, a.id);
              chk("ar_attr", {arsize, arburst, arlock, arcache, arprot}, {3'b010, 2'b01, 9'd0});
            end
          end
          if (awvalid && awready) begin
            if (exp_addr_q.size() == 0) unexpected("aw_extra", awaddr);
            else begin
              a = exp_addr_q.pop_front();
              chk("aw_is_write", a.wr, 1'b1);
              chk("awaddr", awaddr, a.addr);
              chk("awlen", awlen, a.len);
              chk("awid", awid, a.id);
              chk("aw_attr", {awsize, awburst, awlock, awcache, awprot}, {3'b010, 2'b01, 9'd0});
            end
          end
          chk("dc_wnext", dc_wnext, wvalid & wready);
          if (wvalid && wready) begin
            if (exp_w_q.size() == 0) unexpected("w_extra", wdata);
            else begin
              wb = exp_w_q.pop_front();
              chk("wdata", wdata, wb.data);
              chk("wstrb", wstrb, wb.strb);
              chk("wlast", wlast, wb.last);
              chk("wid", wid, DID);
            end
          end
        end
      end
      w_hold   = !rst && wvalid && !wready;
      ar_hold  = !rst && arvalid && !arready;
      w_prev   = wdata;
      rst_prev = rst;
    end
  end

  initial begin : watchdog
    #900000;
    unexpected("global_timeout", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : driver
    plan_t       p, p2;
    int          kind, cyc;
    logic [31:0] a1, a2;
    logic [3:0]  s;
    rst = 1; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_uncached = 0;
    dc_addr = '0; dc_wstrb = '0;
    repeat (3) @(negedge clk);
    rst = 0;

    // Line refill for the I-cache from a mid-line address.
    @(negedge clk);
    issue(1'b0, 1'b0, 1'b0, 32'h1FC0_0014, 4'h0, NO_PLAN);
    wait_done(1'b1, 1'b1 == 1'b0);

    // Simultaneous requests: D-cache must be served first.
    @(negedge clk);
    a1 = $urandom; a2 = $urandom;
    issue(1'b1, 1'b0, 1'b0, a1, 4'h0, NO_PLAN);
    issue(1'b0, 1'b0, 1'b0, a2, 4'h0, NO_PLAN);
    wait_done(1'b1, 1'b1);

    // Uncached partial store.
    @(negedge clk);
    issue(1'b1, 1'b1, 1'b1, 32'hBFAF_8004, 4'b0011, NO_PLAN);
    wait_done(1'b0, 1'b1);

    // Writeback with every beat held off for three cycles.
    @(negedge clk);
    p = NO_PLAN; p.wstall = 4'd3;
    issue(1'b1, 1'b1, 1'b0, $urandom, 4'h5, p);
    wait_done(1'b0, 1'b1);

    // Slave error on beat 3 of a refill.
    @(negedge clk);
    p = NO_PLAN; p.err_beat = 8'sd3; p.rerr = 2'b10;
    issue(1'b1, 1'b0, 1'b0, $urandom, 4'h0, p);
    wait_done(1'b0, 1'b1);

    // Reset in the middle of a refill, then a fresh request.
    @(negedge clk);
    slv_beat = 0;
    issue(1'b1, 1'b0, 1'b0, $urandom, 4'h0, NO_PLAN);
    cyc = 0;
    while (slv_beat < 4 && cyc < 500) begin @(negedge clk); cyc++; end
    if (cyc >= 500) unexpected("beat4_timeout", slv_beat);
    apply_reset();
    repeat (3) @(negedge clk);
    issue(1'b0, 1'b0, 1'b0, $urandom, 4'h0, NO_PLAN);
    wait_done(1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      kind = $urandom_range(0, 5);
      a1 = $urandom; a2 = $urandom; s = 4'($urandom);
      case (kind)
        0: begin issue(1'b0, 1'b0, 1'b0, a1, s, rand_plan(1'b0)); wait_done(1'b1, 1'b0); end
        1: begin issue(1'b1, 1'b0, 1'b0, a1, s, rand_plan(1'b0)); wait_done(1'b0, 1'b1); end
        2: begin issue(1'b1, 1'b0, 1'b1, a1, s, rand_plan(1'b0)); wait_done(1'b0, 1'b1); end
        3: begin issue(1'b1, 1'b1, 1'b0, a1, s, rand_plan(1'b1)); wait_done(1'b0, 1'b1); end
        4: begin issue(1'b1, 1'b1, 1'b1, a1, s, rand_plan(1'b1)); wait_done(1'b0, 1'b1); end
        default: begin
          p  = rand_plan(1'b0);
          p2 = rand_plan(1'b0);
          issue(1'b1, 1'b0, ($urandom_range(0, 1) != 0), a1, s, p);
          issue(1'b0, 1'b0, 1'b0, a2, s, p2);
          wait_done(1'b1, 1'b1);
        end
      endcase
    end

    repeat (10) @(negedge clk);
    chk("left_addr", exp_addr_q.size(), 0);
    chk("left_rdata", exp_ic_q.size() + exp_dc_q.size(), 0);
    chk("left_done", exp_done_q.size(), 0);
    chk("left_w", exp_w_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
